// File: rtl/icm_buffer_set_thread_pkg.sv
// Shared sizing, entry layout and FSM encoding for the ICM buffer set thread.
// Used by the set thread, its way selector and (later) the get thread.
package icm_buffer_set_thread_pkg;

    localparam int unsigned CACHE_ENTRY_WIDTH   = 256;
    localparam int unsigned CACHE_SET_NUM       = 1024;
    localparam int unsigned CACHE_SET_NUM_LOG   = $clog2(CACHE_SET_NUM);
    localparam int unsigned ICM_SLOT_SIZE       = 32;
    localparam int unsigned ICM_SLOT_SIZE_MTT   = 8;
    localparam int unsigned ICM_ENTRY_NUM       = 32768;
    localparam int unsigned CACHE_OFFSET_WIDTH  = $clog2(ICM_SLOT_SIZE);
    localparam int unsigned CACHE_ADDR_WIDTH    = $clog2(ICM_ENTRY_NUM * ICM_SLOT_SIZE);
    localparam int unsigned CACHE_TAG_WIDTH     = CACHE_ADDR_WIDTH - CACHE_OFFSET_WIDTH - CACHE_SET_NUM_LOG;

    localparam int unsigned COUNT_MAX_LOG       = 4;
    localparam int unsigned MAX_REQ_TAG_NUM_LOG = 8;
    localparam int unsigned PHYSICAL_ADDR_WIDTH = 64;
    localparam int unsigned ICM_ADDR_WIDTH      = 64;
    localparam int unsigned HEAD_WIDTH          = COUNT_MAX_LOG * 2 + MAX_REQ_TAG_NUM_LOG
                                                + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH;

    localparam int unsigned ENTRY_WIDTH         = CACHE_ENTRY_WIDTH + CACHE_TAG_WIDTH + 1;

    localparam logic VALID = 1'b1;
    localparam logic WAY_0 = 1'b0;
    localparam logic WAY_1 = 1'b1;

    // SRAM word layout, MSB first
    typedef struct packed {
        logic                         valid;
        logic [CACHE_TAG_WIDTH-1:0]   tag;
        logic [CACHE_ENTRY_WIDTH-1:0] data;
    } cache_entry_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_JUDGE = 2'd1;
    localparam logic [1:0] ST_EVICT = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/icm_way_select.sv
// Combinational target-way choice for a two-way set.
// Ports: way_0_dout/way_1_dout - {valid,tag,data} of each way; lru_dout - MRU way;
//        tag - request tag; target_way_c - chosen way; evict_c - chosen way holds another valid line.
module icm_way_select
    import icm_buffer_set_thread_pkg::*;
(
    input  logic [ENTRY_WIDTH-1:0]     way_0_dout,
    input  logic [ENTRY_WIDTH-1:0]     way_1_dout,
    input  logic                       lru_dout,
    input  logic [CACHE_TAG_WIDTH-1:0] tag,
    output logic                       target_way_c,
    output logic                       evict_c
);

    cache_entry_t e0;
    cache_entry_t e1;
    cache_entry_t victim;
    logic         hit_0;
    logic         hit_1;
    logic         unused_data;

    assign e0          = cache_entry_t'(way_0_dout);
    assign e1          = cache_entry_t'(way_1_dout);
    assign unused_data = ^{e0.data, e1.data};

    // Hit first (way 0 wins a double hit), then a free way, then the non-MRU way
    always_comb begin
        hit_0        = e0.valid && (e0.tag == tag);
        hit_1        = e1.valid && (e1.tag == tag);
        target_way_c = WAY_0;
        if (hit_0)          target_way_c = WAY_0;
        else if (hit_1)     target_way_c = WAY_1;
        else if (!e0.valid) target_way_c = WAY_0;
        else if (!e1.valid) target_way_c = WAY_1;
        else                target_way_c = ~lru_dout;
        victim  = target_way_c ? e1 : e0;
        evict_c = victim.valid && (victim.tag != tag);
    end

endmodule

// File: rtl/icm_buffer_set_thread.sv
// Write-side thread of the two-way ICM buffer: reads the target set, picks a way,
// hands any displaced line to the eviction port, then writes the new line and LRU.
// Ports: set_req_* - fill request; evict_* - displaced line; way_0_*/way_1_*/lru_* - SRAM ports.
module icm_buffer_set_thread
    import icm_buffer_set_thread_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         set_req_valid,
    input  logic [HEAD_WIDTH-1:0]        set_req_head,
    input  logic [CACHE_ENTRY_WIDTH-1:0] set_req_data,
    output logic                         set_req_ready,
    output logic                         evict_valid,
    output logic [CACHE_ADDR_WIDTH-1:0]  evict_head,
    output logic [CACHE_ENTRY_WIDTH-1:0] evict_data,
    input  logic                         evict_ready,
    output logic                         way_0_wen,
    output logic [CACHE_SET_NUM_LOG-1:0] way_0_addr,
    output logic [ENTRY_WIDTH-1:0]       way_0_din,
    input  logic [ENTRY_WIDTH-1:0]       way_0_dout,
    output logic                         way_1_wen,
    output logic [CACHE_SET_NUM_LOG-1:0] way_1_addr,
    output logic [ENTRY_WIDTH-1:0]       way_1_din,
    input  logic [ENTRY_WIDTH-1:0]       way_1_dout,
    output logic                         lru_wen,
    output logic [CACHE_SET_NUM_LOG-1:0] lru_addr,
    output logic                         lru_din,
    input  logic                         lru_dout
);

    localparam int unsigned SET_LO = CACHE_OFFSET_WIDTH;
    localparam int unsigned TAG_LO = CACHE_OFFSET_WIDTH + CACHE_SET_NUM_LOG;

    logic [1:0]                   state_q;
    logic [1:0]                   state_d;
    logic [CACHE_TAG_WIDTH-1:0]   req_tag_q;
    logic [CACHE_SET_NUM_LOG-1:0] req_set_q;
    logic [CACHE_ENTRY_WIDTH-1:0] req_data_q;
    logic                         tgt_way_q;
    logic [CACHE_TAG_WIDTH-1:0]   victim_tag_q;
    logic [CACHE_ENTRY_WIDTH-1:0] victim_data_q;

    logic [CACHE_SET_NUM_LOG-1:0] in_set;
    logic [CACHE_TAG_WIDTH-1:0]   in_tag;
    logic [CACHE_SET_NUM_LOG-1:0] sram_addr;
    logic [ENTRY_WIDTH-1:0]       new_entry;
    logic                         target_way_c;
    logic                         evict_c;
    cache_entry_t                 victim;
    logic                         unused_bits;

    // Only the cache address slice of the header matters; offset is dropped
    assign in_set      = set_req_head[TAG_LO-1:SET_LO];
    assign in_tag      = set_req_head[CACHE_ADDR_WIDTH-1:TAG_LO];
    assign unused_bits = ^{set_req_head[HEAD_WIDTH-1:CACHE_ADDR_WIDTH],
                           set_req_head[SET_LO-1:0], victim.valid};
    assign new_entry   = {VALID, req_tag_q, req_data_q};
    assign victim      = target_way_c ? cache_entry_t'(way_1_dout) : cache_entry_t'(way_0_dout);

    icm_way_select u_way_select (
        .way_0_dout   (way_0_dout),
        .way_1_dout   (way_1_dout),
        .lru_dout     (lru_dout),
        .tag          (req_tag_q),
        .target_way_c (target_way_c),
        .evict_c      (evict_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Request and victim latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_tag_q     <= '0;
            req_set_q     <= '0;
            req_data_q    <= '0;
            tgt_way_q     <= WAY_0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
        end else begin
            if (state_q == ST_IDLE && set_req_valid) begin
                req_tag_q  <= in_tag;
                req_set_q  <= in_set;
                req_data_q <= set_req_data;
            end
            if (state_q == ST_JUDGE) begin
                tgt_way_q     <= target_way_c;
                victim_tag_q  <= victim.tag;
                victim_data_q <= victim.data;
            end
        end
    end

    // Next state and port decode
    always_comb begin
        state_d       = state_q;
        set_req_ready = 1'b0;
        evict_valid   = 1'b0;
        evict_head    = '0;
        evict_data    = '0;
        way_0_wen     = 1'b0;
        way_1_wen     = 1'b0;
        way_0_din     = '0;
        way_1_din     = '0;
        lru_wen       = 1'b0;
        lru_din       = 1'b0;
        sram_addr     = req_set_q;
        case (state_q)
            ST_IDLE: begin
                set_req_ready = 1'b1;
                // Read address goes out with the request so dout lands in JUDGE
                sram_addr     = set_req_valid ? in_set : '0;
                if (set_req_valid) state_d = ST_JUDGE;
            end
            ST_JUDGE: begin
                state_d = evict_c ? ST_EVICT : ST_WRITE;
            end
            ST_EVICT: begin
                evict_valid = 1'b1;
                evict_head  = {victim_tag_q, req_set_q, {CACHE_OFFSET_WIDTH{1'b0}}};
                evict_data  = victim_data_q;
                if (evict_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                way_0_wen = (tgt_way_q == WAY_0);
                way_1_wen = (tgt_way_q == WAY_1);
                way_0_din = (tgt_way_q == WAY_0) ? new_entry : '0;
                way_1_din = (tgt_way_q == WAY_1) ? new_entry : '0;
                lru_wen   = 1'b1;
                lru_din   = tgt_way_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        way_0_addr = sram_addr;
        way_1_addr = sram_addr;
        lru_addr   = sram_addr;
    end

endmodule

// File: tb/tb_icm_buffer_set_thread.sv
// Scoreboard bench for icm_buffer_set_thread: a set-level cache model predicts
// evictions and writes; a negedge monitor checks them as the DUT produces them.
`timescale 1ns/1ps
module tb_icm_buffer_set_thread;
    import icm_buffer_set_thread_pkg::*;

    localparam int unsigned EW = ENTRY_WIDTH;
    localparam int unsigned SL = CACHE_SET_NUM_LOG;
    localparam int unsigned TW = CACHE_TAG_WIDTH;
    localparam int unsigned AW = CACHE_ADDR_WIDTH;
    localparam int unsigned DW = CACHE_ENTRY_WIDTH;
    localparam int unsigned HW = HEAD_WIDTH;
    localparam int unsigned OW = CACHE_OFFSET_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          set_req_valid = 1'b0;
    logic [HW-1:0] set_req_head = '0;
    logic [DW-1:0] set_req_data = '0;
    logic          set_req_ready;
    logic          evict_valid;
    logic [AW-1:0] evict_head;
    logic [DW-1:0] evict_data;
    logic          evict_ready = 1'b0;
    logic          way_0_wen, way_1_wen, lru_wen;
    logic [SL-1:0] way_0_addr, way_1_addr, lru_addr;
    logic [EW-1:0] way_0_din, way_1_din;
    logic [EW-1:0] way_0_dout = '0;
    logic [EW-1:0] way_1_dout = '0;
    logic          lru_din;
    logic          lru_dout = 1'b0;

    always #5 clk = ~clk;

    icm_buffer_set_thread dut (
        .clk(clk), .rst_n(rst_n),
        .set_req_valid(set_req_valid), .set_req_head(set_req_head),
        .set_req_data(set_req_data), .set_req_ready(set_req_ready),
        .evict_valid(evict_valid), .evict_head(evict_head),
        .evict_data(evict_data), .evict_ready(evict_ready),
        .way_0_wen(way_0_wen), .way_0_addr(way_0_addr), .way_0_din(way_0_din), .way_0_dout(way_0_dout),
        .way_1_wen(way_1_wen), .way_1_addr(way_1_addr), .way_1_din(way_1_din), .way_1_dout(way_1_dout),
        .lru_wen(lru_wen), .lru_addr(lru_addr), .lru_din(lru_din), .lru_dout(lru_dout)
    );

    // Write-first SRAMs, one-cycle read latency
    logic [EW-1:0] mem0 [CACHE_SET_NUM] = '{default: '0};
    logic [EW-1:0] mem1 [CACHE_SET_NUM] = '{default: '0};
    logic          meml [CACHE_SET_NUM] = '{default: 1'b0};
    always @(posedge clk) begin
        if (way_0_wen) mem0[way_0_addr] <= way_0_din;
        if (way_1_wen) mem1[way_1_addr] <= way_1_din;
        if (lru_wen)   meml[lru_addr]   <= lru_din;
        way_0_dout <= way_0_wen ? way_0_din : mem0[way_0_addr];
        way_1_dout <= way_1_wen ? way_1_din : mem1[way_1_addr];
        lru_dout   <= lru_wen   ? lru_din   : meml[lru_addr];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference cache contents, per way and set
    bit            m_valid [2][CACHE_SET_NUM];
    logic [TW-1:0] m_tag   [2][CACHE_SET_NUM];
    logic [DW-1:0] m_data  [2][CACHE_SET_NUM];
    bit            m_mru   [CACHE_SET_NUM];

    typedef struct packed {
        logic          is_wr;
        logic          evicts;
        logic          way;
        logic [SL-1:0] set;
        logic [EW-1:0] din;
        logic [AW-1:0] head;
        logic [DW-1:0] data;
        logic [31:0]   acc;
    } ev_t;
    ev_t evq[$];

    int stall_cycles = 0;

    // Eviction sink: forced stalls when requested, otherwise random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (evict_valid && stall_cycles > 0) begin
                evict_ready = 1'b0;
                stall_cycles--;
            end else begin
                evict_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Present one request, predicting its eviction/write from the cache model
    task automatic issue(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int            w;
        logic [SL-1:0] set;
        logic [TW-1:0] tag;
        bit            way;
        bit            ev;
        ev_t           e;
        logic [HW-1:0] h;
        w = 0;
        while (!set_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 300'(set_req_ready), 300'(1));
        set = addr[SL+OW-1:OW];
        tag = addr[AW-1:SL+OW];
        if (m_valid[0][set] && m_tag[0][set] == tag)      way = 1'b0;
        else if (m_valid[1][set] && m_tag[1][set] == tag) way = 1'b1;
        else if (!m_valid[0][set])                        way = 1'b0;
        else if (!m_valid[1][set])                        way = 1'b1;
        else                                              way = !m_mru[set];
        ev = m_valid[way][set] && (m_tag[way][set] != tag);
        e = '0;
        e.acc = cyc;
        e.set = set;
        e.way = way;
        if (ev) begin
            e.head = {m_tag[way][set], set, {OW{1'b0}}};
            e.data = m_data[way][set];
            evq.push_back(e);
        end
        e.is_wr  = 1'b1;
        e.evicts = ev;
        e.din    = {1'b1, tag, data};
        evq.push_back(e);
        m_valid[way][set] = 1'b1;
        m_tag[way][set]   = tag;
        m_data[way][set]  = data;
        m_mru[set]        = way;
        h = HW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        h[AW-1:0] = addr;
        set_req_head  = h;
        set_req_data  = data;
        set_req_valid = 1'b1;
        @(negedge clk);
        set_req_valid = 1'b0;
        set_req_head  = '0;
    endtask

    // Monitor: pops expected events as the DUT presents evictions and writes
    bit            prev_ev = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] st_head;
    logic [DW-1:0] st_data;
    int unsigned   hs_cyc = 0;
    int unsigned   rdy_cyc = 0;
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_ev    = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("evict_hold_valid", 300'(evict_valid), 300'(1));
                chk("evict_hold_head", 300'(evict_head), 300'(st_head));
                chk("evict_hold_data", 300'(evict_data), 300'(st_data));
            end
            if (evict_valid) begin
                chk("evict_no_wen", 300'({way_1_wen, way_0_wen, lru_wen}), 300'(0));
                if (!prev_ev && evq.size() != 0)
                    chk("evict_start_cycle", 300'(cyc), 300'(evq[0].acc + 2));
                if (evict_ready) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_evict", 300'(evict_valid), 300'(0));
                    end else begin
                        e = evq.pop_front();
                        chk("evict_order", 300'(e.is_wr), 300'(0));
                        chk("evict_head", 300'(evict_head), 300'(e.head));
                        chk("evict_data", 300'(evict_data), 300'(e.data));
                        hs_cyc = cyc;
                    end
                end
            end
            if (way_0_wen || way_1_wen || lru_wen) begin
                if (evq.size() == 0) begin
                    chk("unexpected_write", 300'({way_1_wen, way_0_wen, lru_wen}), 300'(0));
                end else begin
                    e = evq.pop_front();
                    chk("write_order", 300'(e.is_wr), 300'(1));
                    chk("write_wen", 300'({way_1_wen, way_0_wen}), 300'(e.way ? 2'b10 : 2'b01));
                    chk("write_lru_wen", 300'(lru_wen), 300'(1));
                    chk("write_addr", 300'(e.way ? way_1_addr : way_0_addr), 300'(e.set));
                    chk("write_lru_addr", 300'(lru_addr), 300'(e.set));
                    chk("write_din", 300'(e.way ? way_1_din : way_0_din), 300'(e.din));
                    chk("write_lru_din", 300'(lru_din), 300'(e.way));
                    chk("write_cycle", 300'(cyc), 300'(e.evicts ? hs_cyc + 1 : e.acc + 2));
                    rdy_cyc = cyc + 1;
                end
            end
            if (rdy_cyc == cyc) chk("ready_again", 300'(set_req_ready), 300'(1));
            prev_ev    = evict_valid;
            prev_stall = evict_valid && !evict_ready;
            st_head    = evict_head;
            st_data    = evict_data;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 300'(set_req_ready), 300'(1));
        chk({tag, "_evict_valid"}, 300'(evict_valid), 300'(0));
        chk({tag, "_wen"}, 300'({way_1_wen, way_0_wen, lru_wen}), 300'(0));
        chk({tag, "_addr"}, 300'({way_0_addr, way_1_addr, lru_addr}), 300'(0));
        chk({tag, "_din"}, 300'({way_0_din, way_1_din, lru_din}), 300'(0));
        chk({tag, "_evict_bus"}, 300'({evict_head, evict_data}), 300'(0));
    endtask

    initial begin
        bit            sv_v [2];
        logic [TW-1:0] sv_t [2];
        logic [DW-1:0] sv_d [2];
        bit            sv_m;
        int            w;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("idle");

        // Empty set, fill second way, evict LRU, hit, stalled eviction
        issue(AW'(20'h00020), DW'(8'hA5));
        issue(AW'(20'h08020), DW'(8'h3C));
        issue(AW'(20'h10020), rand_data());
        issue(AW'(20'h08020), DW'(8'h5A));
        stall_cycles = 5;
        issue(AW'(20'h18020), rand_data());
        w = 0;
        while (evq.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("stall_drain", 300'(evq.size()), 300'(0));
        stall_cycles = 0;

        // Reset while an eviction is pending abandons it
        for (int i = 0; i < 2; i++) begin
            sv_v[i] = m_valid[i][1];
            sv_t[i] = m_tag[i][1];
            sv_d[i] = m_data[i][1];
        end
        sv_m = m_mru[1];
        stall_cycles = 1000;
        issue(AW'(20'h20020), rand_data());
        w = 0;
        while (!evict_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_evict_seen", 300'(evict_valid), 300'(1));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_evict_drop", 300'(evict_valid), 300'(0));
        chk("rst_ready", 300'(set_req_ready), 300'(1));
        chk("rst_wen", 300'({way_1_wen, way_0_wen, lru_wen}), 300'(0));
        evq.delete();
        for (int i = 0; i < 2; i++) begin
            m_valid[i][1] = sv_v[i];
            m_tag[i][1]   = sv_t[i];
            m_data[i][1]  = sv_d[i];
        end
        m_mru[1] = sv_m;
        @(negedge clk);
        #2 rst_n = 1'b1;
        stall_cycles = 0;
        @(negedge clk);

        // Random traffic over a few sets and tags to force hits and conflicts
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            a = {TW'($urandom_range(0, 3)), SL'($urandom_range(0, 3)), OW'($urandom_range(0, 31))};
            issue(a, rand_data());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        w = 0;
        while (evq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("final_drain", 300'(evq.size()), 300'(0));
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
